atomrvcore_mem_stage: RTL and testbench

- Pipeline stage directly downstream of the core ALU stage.
- Consumes the ALU stage's registered outputs: result, address, read/write enables, rd, rd write enable and rs2 store data.
- Performs byte/half/word loads and stores over a req/gnt/rvalid data-memory port and stalls upstream while an access is outstanding.
- Presents registered writeback data, rd and write enable to the register file.

---
 rtl/atomrvcore_mem_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_atomrvcore_mem_stage.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/atomrvcore_mem_stage.sv
// rtl/atomrvcore_mem_stage.sv - memory stage: byte/half/word loads and stores over req/gnt/rvalid
// Stalls upstream while an access is outstanding and registers writeback data for the register file.
module atomrvcore_mem_stage #(
    parameter int DATAWIDTH        = 32,
    parameter int REG_ADRESS_WIDTH = 5
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [DATAWIDTH-1:0]        result_i,
    input  logic [DATAWIDTH-1:0]        address_i,
    input  logic                        DR_EN_i,
    input  logic                        DWR_EN_i,
    input  logic [REG_ADRESS_WIDTH-1:0] RD_i,
    input  logic                        RWR_EN_i,
    input  logic [DATAWIDTH-1:0]        R2_i,
    input  logic [1:0]                  size_i,
    input  logic                        unsigned_i,
    output logic                        mem_req_o,
    output logic                        mem_we_o,
    output logic [DATAWIDTH-1:0]        mem_addr_o,
    output logic [3:0]                  mem_be_o,
    output logic [DATAWIDTH-1:0]        mem_wdata_o,
    input  logic                        mem_gnt_i,
    input  logic                        mem_rvalid_i,
    input  logic [DATAWIDTH-1:0]        mem_rdata_i,
    output logic                        stall_o,
    output logic [DATAWIDTH-1:0]        wb_data_o,
    output logic [REG_ADRESS_WIDTH-1:0] wb_rd_o,
    output logic                        wb_en_o,
    output logic                        misalign_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e state_q, state_d;

    logic                        we_q, we_d;
    logic [DATAWIDTH-1:0]        addr_q, addr_d;
    logic [3:0]                  be_q, be_d;
    logic [DATAWIDTH-1:0]        wdata_q, wdata_d;
    logic [1:0]                  off_q, off_d;
    logic [1:0]                  size_q, size_d;
    logic                        uns_q, uns_d;
    logic [REG_ADRESS_WIDTH-1:0] rd_q, rd_d;
    logic                        wen_q, wen_d;

    logic [DATAWIDTH-1:0]        wb_data_q, wb_data_d;
    logic [REG_ADRESS_WIDTH-1:0] wb_rd_q, wb_rd_d;
    logic                        wb_en_q, wb_en_d;
    logic                        misalign_q, misalign_d;

    logic                        access;
    logic                        misaligned;
    logic                        start;
    logic [3:0]                  be_calc;
    logic [DATAWIDTH-1:0]        wdata_calc;
    logic [7:0]                  load_byte;
    logic [15:0]                 load_half;
    logic [DATAWIDTH-1:0]        load_fmt;

    assign access     = DR_EN_i | DWR_EN_i;
    assign misaligned = ((size_i == 2'b01) && address_i[0]) ||
                        (size_i[1] && (address_i[1:0] != 2'b00));
    assign start      = access && !misaligned;

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = R2_i;
        case (size_i)
            2'b00: begin
                be_calc    = 4'b0001 << address_i[1:0];
                wdata_calc = {4{R2_i[7:0]}};
            end
            2'b01: begin
                be_calc    = address_i[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{R2_i[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = R2_i;
            end
        endcase
    end

    // Lane selection replaces a full barrel shift: only the low byte/half survives formatting.
    always_comb begin
        load_byte = mem_rdata_i[7:0];
        case (off_q)
            2'b00:   load_byte = mem_rdata_i[7:0];
            2'b01:   load_byte = mem_rdata_i[15:8];
            2'b10:   load_byte = mem_rdata_i[23:16];
            default: load_byte = mem_rdata_i[31:24];
        endcase
        load_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (size_q)
            2'b00:   load_fmt = {{(DATAWIDTH-8){load_byte[7] & ~uns_q}}, load_byte};
            2'b01:   load_fmt = {{(DATAWIDTH-16){load_half[15] & ~uns_q}}, load_half};
            default: load_fmt = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = REQ;
            REQ:     if (mem_gnt_i) state_d = we_q ? DONE : WAIT;
            WAIT:    if (mem_rvalid_i) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_o = 1'b0;
        stall_o   = 1'b0;
        case (state_q)
            IDLE:    stall_o = start & rst_ni;
            REQ: begin
                mem_req_o = 1'b1;
                stall_o   = 1'b1;
            end
            WAIT:    stall_o = 1'b1;
            default: stall_o = 1'b0;
        endcase
    end

    always_comb begin
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        off_d      = off_q;
        size_d     = size_q;
        uns_d      = uns_q;
        rd_d       = rd_q;
        wen_d      = wen_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_en_d    = 1'b0;
        misalign_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && misaligned) begin
                    misalign_d = 1'b1;
                end else if (start) begin
                    we_d    = DWR_EN_i;
                    addr_d  = {address_i[DATAWIDTH-1:2], 2'b00};
                    be_d    = be_calc;
                    wdata_d = wdata_calc;
                    off_d   = address_i[1:0];
                    size_d  = size_i;
                    uns_d   = unsigned_i;
                    rd_d    = RD_i;
                    wen_d   = RWR_EN_i;
                end else if (RWR_EN_i && (RD_i != '0)) begin
                    wb_en_d   = 1'b1;
                    wb_data_d = result_i;
                    wb_rd_d   = RD_i;
                end
            end
            WAIT: begin
                if (mem_rvalid_i && wen_q && (rd_q != '0)) begin
                    wb_en_d   = 1'b1;
                    wb_data_d = load_fmt;
                    wb_rd_d   = rd_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            off_q      <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            rd_q       <= '0;
            wen_q      <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_en_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            off_q      <= off_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            rd_q       <= rd_d;
            wen_q      <= wen_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_en_q    <= wb_en_d;
            misalign_q <= misalign_d;
        end
    end

    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;
    assign wb_data_o   = wb_data_q;
    assign wb_rd_o     = wb_rd_q;
    assign wb_en_o     = wb_en_q;
    assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_atomrvcore_mem_stage.sv
// tb/tb_atomrvcore_mem_stage.sv - directed-vector bench for atomrvcore_mem_stage
module tb_atomrvcore_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] result_i, address_i, R2_i, mem_rdata_i;
    logic        DR_EN_i, DWR_EN_i, RWR_EN_i, unsigned_i;
    logic [4:0]  RD_i;
    logic [1:0]  size_i;
    logic        mem_gnt_i, mem_rvalid_i;
    logic        mem_req_o, mem_we_o, stall_o, wb_en_o, misalign_o;
    logic [31:0] mem_addr_o, mem_wdata_o, wb_data_o;
    logic [3:0]  mem_be_o;
    logic [4:0]  wb_rd_o;

    int n_vec = 0;
    int n_err = 0;

    atomrvcore_mem_stage dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .result_i(result_i), .address_i(address_i),
        .DR_EN_i(DR_EN_i), .DWR_EN_i(DWR_EN_i), .RD_i(RD_i), .RWR_EN_i(RWR_EN_i),
        .R2_i(R2_i), .size_i(size_i), .unsigned_i(unsigned_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .stall_o(stall_o),
        .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o), .wb_en_o(wb_en_o), .misalign_o(misalign_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        DR_EN_i = 0; DWR_EN_i = 0; RWR_EN_i = 0; RD_i = 0; result_i = 0;
        address_i = 0; R2_i = 0; size_i = 0; unsigned_i = 0;
    endtask

    // Drives one aligned access from IDLE through to DONE; returns with the DUT in DONE.
    task automatic run_mem(input string tag, input logic st, input logic [31:0] addr,
                           input logic [1:0] sz, input logic uns, input logic [4:0] rd,
                           input logic [31:0] r2, input int gnt_dly, input logic [31:0] rdata,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata);
        DWR_EN_i = st; DR_EN_i = 1'b1; address_i = addr; size_i = sz; unsigned_i = uns;
        RD_i = rd; RWR_EN_i = 1'b1; R2_i = r2; result_i = 32'hCAFE0000;
        #1;
        chk({tag, " stall_idle"}, {31'b0, stall_o}, 1);
        chk({tag, " req_idle"}, {31'b0, mem_req_o}, 0);
        tick();
        for (int i = 0; i <= gnt_dly; i++) begin
            chk($sformatf("%s req[%0d]", tag, i), {31'b0, mem_req_o}, 1);
            chk($sformatf("%s addr[%0d]", tag, i), mem_addr_o, exp_addr);
            chk($sformatf("%s be[%0d]", tag, i), {28'b0, mem_be_o}, {28'b0, exp_be});
            chk($sformatf("%s we[%0d]", tag, i), {31'b0, mem_we_o}, {31'b0, st});
            if (st) chk($sformatf("%s wdata[%0d]", tag, i), mem_wdata_o, exp_wdata);
            mem_gnt_i = (i == gnt_dly);
            tick();
        end
        mem_gnt_i = 0;
        if (!st) begin
            chk({tag, " req_wait"}, {31'b0, mem_req_o}, 0);
            chk({tag, " stall_wait"}, {31'b0, stall_o}, 1);
            mem_rvalid_i = 1; mem_rdata_i = rdata;
            tick();
            mem_rvalid_i = 0; mem_rdata_i = 0;
        end
        chk({tag, " stall_done"}, {31'b0, stall_o}, 0);
    endtask

    initial begin
        rst_ni = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        idle_inputs();
        tick(); tick();
        chk("rst req", {31'b0, mem_req_o}, 0);
        chk("rst stall", {31'b0, stall_o}, 0);
        chk("rst wb_en", {31'b0, wb_en_o}, 0);
        chk("rst wb_data", wb_data_o, 0);
        chk("rst misalign", {31'b0, misalign_o}, 0);
        rst_ni = 1;
        tick();

        // non-memory writeback
        result_i = 32'h1234; RD_i = 5; RWR_EN_i = 1;
        #1;
        chk("alu stall", {31'b0, stall_o}, 0);
        tick();
        chk("alu wb_en", {31'b0, wb_en_o}, 1);
        chk("alu wb_rd", {27'b0, wb_rd_o}, 5);
        chk("alu wb_data", wb_data_o, 32'h1234);
        chk("alu stall2", {31'b0, stall_o}, 0);
        idle_inputs();
        tick();
        chk("alu wb_en off", {31'b0, wb_en_o}, 0);
        chk("alu wb_data hold", wb_data_o, 32'h1234);

        run_mem("lw", 0, 32'h100, 2'b10, 0, 5'd3, 0, 0, 32'hDEADBEEF, 32'h100, 4'hF, 0);
        chk("lw wb_en", {31'b0, wb_en_o}, 1);
        chk("lw wb_rd", {27'b0, wb_rd_o}, 3);
        chk("lw wb_data", wb_data_o, 32'hDEADBEEF);
        idle_inputs(); tick();
        chk("lw wb_en off", {31'b0, wb_en_o}, 0);

        run_mem("lb", 0, 32'h103, 2'b00, 0, 5'd6, 0, 0, 32'h80AABBCC, 32'h100, 4'b1000, 0);
        chk("lb wb_data", wb_data_o, 32'hFFFFFF80);
        idle_inputs(); tick();
        run_mem("lbu", 0, 32'h103, 2'b00, 1, 5'd6, 0, 0, 32'h80AABBCC, 32'h100, 4'b1000, 0);
        chk("lbu wb_data", wb_data_o, 32'h00000080);
        idle_inputs(); tick();
        run_mem("lh", 0, 32'h202, 2'b01, 0, 5'd9, 0, 1, 32'h80011234, 32'h200, 4'b1100, 0);
        chk("lh wb_data", wb_data_o, 32'hFFFF8001);
        chk("lh wb_rd", {27'b0, wb_rd_o}, 9);
        idle_inputs(); tick();

        run_mem("sh", 1, 32'h102, 2'b01, 0, 5'd7, 32'h0000BEEF, 3, 0, 32'h100, 4'b1100, 32'hBEEFBEEF);
        chk("sh wb_en", {31'b0, wb_en_o}, 0);
        idle_inputs(); tick();
        run_mem("sb", 1, 32'h101, 2'b00, 0, 5'd7, 32'h123456A5, 0, 0, 32'h100, 4'b0010, 32'hA5A5A5A5);
        chk("sb wb_en", {31'b0, wb_en_o}, 0);
        idle_inputs(); tick();

        // misaligned word load
        DR_EN_i = 1; size_i = 2'b10; address_i = 32'h101; RD_i = 4; RWR_EN_i = 1;
        #1;
        chk("mis stall", {31'b0, stall_o}, 0);
        chk("mis req0", {31'b0, mem_req_o}, 0);
        tick();
        chk("mis pulse", {31'b0, misalign_o}, 1);
        chk("mis wb_en", {31'b0, wb_en_o}, 0);
        chk("mis req1", {31'b0, mem_req_o}, 0);
        idle_inputs(); tick();
        chk("mis pulse end", {31'b0, misalign_o}, 0);

        run_mem("lw_x0", 0, 32'h200, 2'b10, 0, 5'd0, 0, 0, 32'h55, 32'h200, 4'hF, 0);
        chk("lw_x0 wb_en", {31'b0, wb_en_o}, 0);
        chk("lw_x0 wb_data hold", wb_data_o, 32'hFFFF8001);
        idle_inputs(); tick();

        // reset while waiting for rvalid
        DR_EN_i = 1; size_i = 2'b10; address_i = 32'h300; RD_i = 2; RWR_EN_i = 1;
        tick();
        mem_gnt_i = 1; tick(); mem_gnt_i = 0;
        chk("rw stall_wait", {31'b0, stall_o}, 1);
        rst_ni = 0;
        #1;
        chk("rw req_rst", {31'b0, mem_req_o}, 0);
        chk("rw stall_rst", {31'b0, stall_o}, 0);
        chk("rw wb_en_rst", {31'b0, wb_en_o}, 0);
        tick();
        rst_ni = 1; idle_inputs();
        mem_rvalid_i = 1; mem_rdata_i = 32'h77777777;
        tick();
        mem_rvalid_i = 0;
        chk("rw wb_en_after", {31'b0, wb_en_o}, 0);
        chk("rw wb_data_after", wb_data_o, 0);
        chk("rw stall_after", {31'b0, stall_o}, 0);
        chk("rw req_after", {31'b0, mem_req_o}, 0);
        tick();
        chk("rw wb_en_later", {31'b0, wb_en_o}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
